// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the store trace capture path.
package trace_pkg;

    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int TRACE_ADDR_W        = 12;

    typedef struct packed {
        logic [31:0]             pc;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [31:0]             data;
    } trace_entry_t;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; occupancy drives full/empty, not pointer equality.
// The caller guarantees pop_i only when valid_o is high and push_i only when not full or popping.
module sync_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH = 76,
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = level_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;
    logic             r_full;

    logic [PTR_W-1:0] w_rd_next;
    logic [LVL_W-1:0] w_level_next;
    logic [WIDTH-1:0] w_head_next;

    // Next read pointer, occupancy and head word; an empty FIFO presents an all-zero head.
    always_comb begin
        w_rd_next    = r_rd_ptr;
        w_level_next = r_level;
        w_head_next  = {WIDTH{1'b0}};
        if (pop_i) begin
            w_rd_next = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_next = r_rd_ptr;
        end
        case ({push_i, pop_i})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
        // When nothing older survives the pop, the word being pushed becomes the new head.
        if (w_level_next == {LVL_W{1'b0}}) begin
            w_head_next = {WIDTH{1'b0}};
        end else if ((r_level - LVL_W'(pop_i)) == {LVL_W{1'b0}}) begin
            w_head_next = din_i;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array write port; contents are never reset and only read once written.
    always_ff @(posedge CLK) begin
        if (push_i && !RST && !clr_i) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointer, occupancy and registered head state.
    always_ff @(posedge CLK) begin
        if (RST || clr_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
            r_head   <= {WIDTH{1'b0}};
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_head   <= w_head_next;
            r_valid  <= (w_level_next != {LVL_W{1'b0}});
            r_full   <= (w_level_next == LVL_W'(DEPTH));
        end
    end

    assign dout_o  = r_head;
    assign valid_o = r_valid;
    assign level_o = r_level;
    assign full_o  = r_full;

endmodule

// File: rtl/store_trace_fifo.sv
// Captures CPU data-memory stores as {pc, addr, data} entries and drains them over valid/ready.
// Head outputs read as zero whenever out_valid_o is low.
module store_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH_DEFAULT,
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [31:0]                   pc_i,
    input  logic                          mem_we_i,
    input  logic [31:0]                   mem_addr_i,
    input  logic [31:0]                   mem_wdata_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_pc_o,
    output logic [ADDR_W-1:0]             out_addr_o,
    output logic [31:0]                   out_data_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic                          full_o
);

    localparam int LVL_W   = level_width(DEPTH);
    localparam int ENTRY_W = 64 + ADDR_W;

    logic               w_store;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_valid;
    logic               w_full;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;
    logic [LVL_W-1:0]   w_level;
    logic [CNT_W-1:0]   r_drop_cnt;

    // Only the low address bits are traced; the rest are deliberately ignored.
    generate
        if (ADDR_W < 32) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^mem_addr_i[31:ADDR_W];
        end
    endgenerate

    // A pop on a full FIFO frees the slot in the same edge, so the store is still accepted.
    assign w_store = enable_i & mem_we_i;
    assign w_pop   = w_valid & out_ready_i & ~clear_i;
    assign w_push  = w_store & (~w_full | w_pop) & ~clear_i;
    assign w_drop  = w_store & w_full & ~w_pop & ~clear_i;
    assign w_din   = {pc_i, mem_addr_i[ADDR_W-1:0], mem_wdata_i};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W ($clog2(DEPTH)),
        .LVL_W (LVL_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (clear_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .dout_o  (w_dout),
        .valid_o (w_valid),
        .level_o (w_level),
        .full_o  (w_full)
    );

    // Saturating count of stores lost to a full FIFO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_cnt <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            r_drop_cnt <= {CNT_W{1'b0}};
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign out_valid_o = w_valid;
    assign out_pc_o    = w_dout[ENTRY_W-1 -: 32];
    assign out_addr_o  = w_dout[32 +: ADDR_W];
    assign out_data_o  = w_dout[31:0];
    assign level_o     = w_level;
    assign full_o      = w_full;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_store_trace_fifo;
    import trace_pkg::*;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        enable_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [11:0] out_addr_o;
    logic [31:0] out_data_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        full_o;

    int n_checks = 0;
    int n_errors = 0;

    trace_entry_t m_q[$];
    int           m_drop = 0;
    int           max_level;

    store_trace_fifo dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .pc_i        (pc_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .level_o     (level_o),
        .drop_cnt_o  (drop_cnt_o),
        .full_o      (full_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, applied to the pre-edge model state.
    task automatic model_edge();
        bit           full_now;
        bit           pop;
        bit           store;
        trace_entry_t e;
        if (RST || clear_i) begin
            m_q.delete();
            m_drop = 0;
        end else begin
            full_now = (m_q.size() == DEPTH);
            pop      = (m_q.size() > 0) && out_ready_i;
            store    = enable_i && mem_we_i;
            if (pop) void'(m_q.pop_front());
            if (store && (!full_now || pop)) begin
                e.pc   = pc_i;
                e.addr = mem_addr_i[11:0];
                e.data = mem_wdata_i;
                m_q.push_back(e);
            end else if (store) begin
                if (m_drop < 65535) m_drop++;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 64'(out_valid_o), 64'(m_q.size() > 0));
        check("level", 64'(level_o), 64'(m_q.size()));
        check("full", 64'(full_o), 64'(m_q.size() == DEPTH));
        check("drop", 64'(drop_cnt_o), 64'(m_drop));
        if (m_q.size() > 0) begin
            check("pc", 64'(out_pc_o), 64'(m_q[0].pc));
            check("addr", 64'(out_addr_o), 64'(m_q[0].addr));
            check("data", 64'(out_data_o), 64'(m_q[0].data));
        end else begin
            check("pc0", 64'(out_pc_o), 64'h0);
            check("addr0", 64'(out_addr_o), 64'h0);
            check("data0", 64'(out_data_o), 64'h0);
        end
        if (m_q.size() > max_level) max_level = m_q.size();
    endtask

    task automatic cyc(input bit rst, input bit clr, input bit en, input bit we, input bit rdy,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        RST = rst; clear_i = clr; enable_i = en; mem_we_i = we; out_ready_i = rdy;
        pc_i = pc; mem_addr_i = addr; mem_wdata_i = data;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rdy, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        // Reset held two cycles
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(1'b0);
        check("rst_valid", 64'(out_valid_o), 64'h0);
        check("rst_level", 64'(level_o), 64'h0);

        // Single store, held, then popped
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0010, 32'hDEADBEEF);
        check("single_valid", 64'(out_valid_o), 64'h1);
        check("single_pc", 64'(out_pc_o), 64'h40);
        check("single_addr", 64'(out_addr_o), 64'h10);
        check("single_data", 64'(out_data_o), 64'hDEADBEEF);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("hold_data", 64'(out_data_o), 64'hDEADBEEF);
        idle(1'b1);
        check("single_popped", 64'(out_valid_o), 64'h0);
        check("single_lvl0", 64'(level_o), 64'h0);

        // Overflow: 20 stores into 16 slots
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 32'(i * 4), 32'(i));
        check("ovf_full", 64'(full_o), 64'h1);
        check("ovf_level", 64'(level_o), 64'd16);
        check("ovf_drop", 64'(drop_cnt_o), 64'd4);
        check("ovf_head", 64'(out_data_o), 64'h0);

        // Push with simultaneous pop while full
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 32'hAA);
        check("fp_level", 64'(level_o), 64'd16);
        check("fp_drop", 64'(drop_cnt_o), 64'd4);
        check("fp_head", 64'(out_data_o), 64'h1);
        for (int i = 0; i < 15; i++) idle(1'b1);
        check("fp_last", 64'(out_data_o), 64'hAA);
        idle(1'b1);
        check("fp_empty", 64'(out_valid_o), 64'h0);

        // Capture disabled, then clear together with a store
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h10, 32'(i));
        check("dis_level", 64'(level_o), 64'h0);
        check("dis_drop", 64'(drop_cnt_o), 64'h4);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h20, 32'(i));
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h30, 32'h77);
        check("clr_level", 64'(level_o), 64'h0);
        check("clr_valid", 64'(out_valid_o), 64'h0);
        check("clr_drop", 64'(drop_cnt_o), 64'h0);

        // Streaming with ready held high: 40 stores, wraps pointers
        max_level = 0;
        for (int i = 0; i < 40; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i), $urandom, 32'(i));
        idle(1'b1);
        check("stream_maxlvl", 64'(max_level <= 1), 64'h1);
        check("stream_drop", 64'(drop_cnt_o), 64'h0);
        check("stream_empty", 64'(level_o), 64'h0);

        // Reset in the middle of a drain
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom);
        idle(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3);
        check("mrst_level", 64'(level_o), 64'h0);
        check("mrst_valid", 64'(out_valid_o), 64'h0);

        // Random traffic with occasional clear and reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) == 0) || (i % 600 > 300),
                $urandom, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
